jam_cost_loader: RTL

//  Upstream feeder for the job-assignment (JAM) search engine. Accepts the 8x8 worker/job

---
 rtl/jam_cost_loader_pkg.sv | 20 ++
 rtl/jam_cost_mem.sv | 33 +++
 rtl/jam_cost_loader.sv | 96 +++++++++
 3 files changed

// File: rtl/jam_cost_loader_pkg.sv
// Shared constants, loader state encoding and index helper for the JAM cost loader.
// Optional feature macro used by the top level: JAM_COST_SUM_EN.
package jam_cost_loader_pkg;

    localparam int JAM_N      = 8;
    localparam int JAM_COST_W = 7;
    localparam int JAM_IDX_W  = 6;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } load_state_t;

    // Row-major flat index of table[w][j]
    function automatic logic [JAM_IDX_W-1:0] cost_idx(input logic [2:0] w, input logic [2:0] j);
        return {w, j};
    endfunction

endpackage

// File: rtl/jam_cost_mem.sv
// N*N x COST_W register file: one synchronous write port, one combinational read port.
module jam_cost_mem
    import jam_cost_loader_pkg::*;
#(
    parameter int N      = JAM_N,
    parameter int COST_W = JAM_COST_W,
    parameter int IDX_W  = JAM_IDX_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [COST_W-1:0] rdata
);

    logic [COST_W-1:0] entries [N*N];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N*N; i++) begin
                entries[i] <= '0;
            end
        end else if (we) begin
            entries[waddr] <= wdata;
        end
    end

    // Read sees the pre-write value during a same-cycle write
    assign rdata = entries[raddr];

endmodule

// File: rtl/jam_cost_loader.sv
// Streams the 8x8 JAM cost matrix into a register file and holds the engine in reset until loaded.
// Optional running-sum output cost_sum enabled by defining JAM_COST_SUM_EN.
module jam_cost_loader
    import jam_cost_loader_pkg::*;
#(
    parameter int N      = JAM_N,
    parameter int COST_W = JAM_COST_W,
    parameter int IDX_W  = JAM_IDX_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_cost,
    input  logic              reload,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
`ifdef JAM_COST_SUM_EN
    output logic [12:0]       cost_sum,
`endif
    output logic              table_ready,
    output logic              JAM_RST
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N*N - 1);

    load_state_t      state;
    load_state_t      state_nxt;
    logic [IDX_W-1:0] wr_idx;
    logic             hs;
    logic             we;

    assign in_ready = (state == LOAD);
    assign hs       = in_valid && in_ready;
    // reload wins over a same-cycle handshake: the entry is dropped
    assign we       = hs && !reload;

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (hs && wr_idx == LAST_IDX) state_nxt = ARM;
            ARM:     state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = LOAD;
        endcase
        if (reload) begin
            state_nxt = LOAD;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= LOAD;
            wr_idx      <= '0;
            table_ready <= 1'b0;
            JAM_RST     <= 1'b1;
        end else begin
            state       <= state_nxt;
            table_ready <= (state_nxt == RUN);
            JAM_RST     <= (state_nxt != RUN);
            if (reload) begin
                wr_idx <= '0;
            end else if (hs) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
        end
    end

`ifdef JAM_COST_SUM_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cost_sum <= '0;
        end else if (reload) begin
            cost_sum <= '0;
        end else if (hs) begin
            cost_sum <= cost_sum + 13'(in_cost);
        end
    end
`endif

    jam_cost_mem #(
        .N      (N),
        .COST_W (COST_W),
        .IDX_W  (IDX_W)
    ) u_mem (
        .CLK   (CLK),
        .RST_N (RST_N),
        .we    (we),
        .waddr (wr_idx),
        .wdata (in_cost),
        .raddr (cost_idx(W, J)),
        .rdata (Cost)
    );

endmodule
